// File: rtl/ddr_prbs31_chk.sv
// Receive-side PRBS31 checker: self-synchronises to a 32-bit parallel PRBS31 stream,
// then checks each valid word against a locally advanced prediction and keeps statistics.
module ddr_prbs31_chk #(
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned UNLOCK_THR = 8,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             prbs_vld,
    input  logic [31:0]      prbs_data_i,
    input  logic             clr_cnt,
    output logic             prbs_lock,
    output logic             prbs_err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] err_word_cnt,
    output logic [CNT_W-1:0] err_bit_cnt,
    output logic [15:0]      unlock_cnt
);

    typedef enum logic [1:0] {StHunt, StVerify, StLocked} state_t;

    localparam logic [7:0]       LockCnt   = 8'(LOCK_CNT);
    localparam logic [7:0]       UnlockThr = 8'(UNLOCK_THR);
    localparam logic [CNT_W-1:0] CntOne    = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [31:0] prbs_next(input logic [31:0] d);
        logic [31:0] n;
        n[0] = d[24] ^ d[30];
        n[1] = d[0] ^ d[25] ^ d[28];
        n[2] = d[1] ^ d[26] ^ d[29];
        n[3] = d[2] ^ d[27] ^ d[30];
        for (int i = 4; i < 32; i++) begin
            n[i] = d[i-4] ^ d[i-1];
        end
        return n;
    endfunction

    function automatic logic [5:0] popcount(input logic [31:0] d);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) begin
            c = c + {5'd0, d[i]};
        end
        return c;
    endfunction

    state_t             r_state;
    logic [31:0]        r_seed;
    logic [31:0]        r_exp;
    logic [7:0]         r_match;
    logic [7:0]         r_bad;
    logic               r_lock;
    logic               r_err;
    logic               r_sticky;
    logic [CNT_W-1:0]   r_word_cnt;
    logic [CNT_W-1:0]   r_err_word_cnt;
    logic [CNT_W-1:0]   r_err_bit_cnt;
    logic [15:0]        r_unlock_cnt;

    logic [31:0]        w_seed_nxt;
    logic [31:0]        w_exp_nxt;
    logic [31:0]        w_diff;
    logic               w_mis;
    logic [5:0]         w_nbits;
    logic [CNT_W+5:0]   w_bit_sum;
    logic [CNT_W-1:0]   w_bit_sat;
    logic [7:0]         w_match_inc;
    logic [7:0]         w_bad_inc;

    assign w_seed_nxt  = prbs_next(r_seed);
    assign w_exp_nxt   = prbs_next(r_exp);
    assign w_diff      = prbs_data_i ^ w_exp_nxt;
    assign w_mis       = |w_diff;
    assign w_nbits     = popcount(w_diff);
    // Extra headroom bits so a large add can be detected and clamped instead of wrapping.
    assign w_bit_sum   = {6'd0, r_err_bit_cnt} + {{CNT_W{1'b0}}, w_nbits};
    assign w_bit_sat   = (w_bit_sum[CNT_W+5:CNT_W] != 6'd0) ? '1 : w_bit_sum[CNT_W-1:0];
    assign w_match_inc = r_match + 8'd1;
    assign w_bad_inc   = r_bad + 8'd1;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state        <= StHunt;
            r_seed         <= '0;
            r_exp          <= '0;
            r_match        <= '0;
            r_bad          <= '0;
            r_lock         <= 1'b0;
            r_err          <= 1'b0;
            r_sticky       <= 1'b0;
            r_word_cnt     <= '0;
            r_err_word_cnt <= '0;
            r_err_bit_cnt  <= '0;
            r_unlock_cnt   <= '0;
        end else begin
            r_err <= 1'b0;
            if (prbs_vld) begin
                unique case (r_state)
                    StHunt: begin
                        if (prbs_data_i != 32'd0) begin
                            r_seed  <= prbs_data_i;
                            r_match <= '0;
                            r_state <= StVerify;
                        end
                    end
                    StVerify: begin
                        r_seed <= prbs_data_i;
                        if (prbs_data_i == w_seed_nxt) begin
                            r_match <= w_match_inc;
                            if (w_match_inc == LockCnt) begin
                                r_state <= StLocked;
                                r_exp   <= prbs_data_i;
                                r_lock  <= 1'b1;
                                r_bad   <= '0;
                            end
                        end else begin
                            r_match <= '0;
                            if (prbs_data_i == 32'd0) r_state <= StHunt;
                        end
                    end
                    StLocked: begin
                        // Free-running prediction: received data never feeds back here.
                        r_exp <= w_exp_nxt;
                        if (r_word_cnt != '1) r_word_cnt <= r_word_cnt + CntOne;
                        if (w_mis) begin
                            if (r_err_word_cnt != '1) r_err_word_cnt <= r_err_word_cnt + CntOne;
                            r_err_bit_cnt <= w_bit_sat;
                            r_err         <= 1'b1;
                            r_sticky      <= 1'b1;
                            if (w_bad_inc == UnlockThr) begin
                                r_state <= StHunt;
                                r_lock  <= 1'b0;
                                r_bad   <= '0;
                                if (r_unlock_cnt != 16'hFFFF) r_unlock_cnt <= r_unlock_cnt + 16'd1;
                            end else begin
                                r_bad <= w_bad_inc;
                            end
                        end else begin
                            r_bad <= '0;
                        end
                    end
                    default: r_state <= StHunt;
                endcase
            end
            // Placed last so a clear overrides any increment from the same word.
            if (clr_cnt) begin
                r_word_cnt     <= '0;
                r_err_word_cnt <= '0;
                r_err_bit_cnt  <= '0;
                r_unlock_cnt   <= '0;
                r_sticky       <= 1'b0;
            end
        end
    end

    assign prbs_lock    = r_lock;
    assign prbs_err     = r_err;
    assign err_sticky   = r_sticky;
    assign word_cnt     = r_word_cnt;
    assign err_word_cnt = r_err_word_cnt;
    assign err_bit_cnt  = r_err_bit_cnt;
    assign unlock_cnt   = r_unlock_cnt;

endmodule
